// File: rtl/e203_exu_wbck_arb_pkg.sv
// Shared writeback types and widths for the EXU writeback arbiter.
// Holds the request bundle carried from each source to the regfile port.
package e203_exu_pkg;

  localparam int XLEN    = 32;
  localparam int RFIDX_W = 5;

  typedef struct packed {
    logic [RFIDX_W-1:0] idx;
    logic [XLEN-1:0]    dat;
  } wbck_req_t;

  function automatic logic is_x0(input wbck_req_t r);
    return ~(|r.idx);
  endfunction

endpackage

// File: rtl/e203_exu_wbck_arb_if.sv
// Writeback bundle: two request channels plus the regfile write port.
// slave = arbiter side, master = sources and regfile side.
interface e203_exu_wbck_arb_if;
  import e203_exu_pkg::*;

  logic               alu_wbck_valid;
  logic               alu_wbck_ready;
  logic [RFIDX_W-1:0] alu_wbck_idx;
  logic [XLEN-1:0]    alu_wbck_dat;

  logic               longp_wbck_valid;
  logic               longp_wbck_ready;
  logic [RFIDX_W-1:0] longp_wbck_idx;
  logic [XLEN-1:0]    longp_wbck_dat;

  logic               rf_wbck_wen;
  logic [RFIDX_W-1:0] rf_wbck_idx;
  logic [XLEN-1:0]    rf_wbck_dat;

  modport slave (
    input  alu_wbck_valid, alu_wbck_idx,
    input  alu_wbck_dat,
    output alu_wbck_ready,
    input  longp_wbck_valid, longp_wbck_idx,
    input  longp_wbck_dat,
    output longp_wbck_ready,
    output rf_wbck_wen, rf_wbck_idx, rf_wbck_dat
  );

  modport master (
    output alu_wbck_valid, alu_wbck_idx,
    output alu_wbck_dat,
    input  alu_wbck_ready,
    output longp_wbck_valid, longp_wbck_idx,
    output longp_wbck_dat,
    input  longp_wbck_ready,
    input  rf_wbck_wen, rf_wbck_idx, rf_wbck_dat
  );

endinterface

// File: rtl/e203_exu_wbck_arb_starve_cnt.sv
// Counts consecutive ALU-losing cycles and raises a one-cycle
// forced ALU grant once the limit is reached.
module e203_exu_wbck_starve_cnt #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic alu_valid,
  input  logic alu_hsk,
  input  logic longp_hsk,
  output logic starve_force
);

  localparam int CW =
    (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] MAX_C = CW'(STARVE_MAX);
  localparam logic          EN    = (STARVE_MAX != 0);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_nxt;

  assign starve_force = EN & (cnt_q == MAX_C) & alu_valid;

  always_comb begin
    cnt_nxt = cnt_q;
    unique case (1'b1)
      alu_hsk:              cnt_nxt = '0;
      alu_valid & longp_hsk:
        cnt_nxt = (cnt_q == MAX_C) ? cnt_q : cnt_q + 1'b1;
      ~alu_valid:           cnt_nxt = '0;
      default:              cnt_nxt = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_nxt;
  end

endmodule

// File: rtl/sirv_gnrl_dffs.sv
// General load-enable flop with async active-low reset to zero.
module sirv_gnrl_dfflr #(
  parameter int DW = 32
) (
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout,
  input  logic          clk,
  input  logic          rst_n
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    qout <= '0;
    else if (lden) qout <= dnxt;
  end

endmodule

// File: rtl/e203_exu_wbck_arb.sv
// Regfile write-port arbiter: long-pipe has priority, ALU is
// periodically forced through; the winning write is registered.
module e203_exu_wbck_arb
  import e203_exu_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  e203_exu_wbck_arb_if.slave  wb,
  output logic                starve_force
);

  logic      alu_hsk;
  logic      longp_hsk;
  logic      any_hsk;
  logic      wen_nxt;
  logic      wen_q;
  wbck_req_t alu_req;
  wbck_req_t longp_req;
  wbck_req_t win_req;
  wbck_req_t rf_q;

  e203_exu_wbck_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_valid    (wb.alu_wbck_valid),
    .alu_hsk      (alu_hsk),
    .longp_hsk    (longp_hsk),
    .starve_force (starve_force)
  );

  assign wb.longp_wbck_ready = ~starve_force;
  assign wb.alu_wbck_ready   =
    ~wb.longp_wbck_valid | starve_force;

  assign alu_hsk   = wb.alu_wbck_valid
                   & wb.alu_wbck_ready;
  assign longp_hsk = wb.longp_wbck_valid
                   & wb.longp_wbck_ready;
  assign any_hsk   = alu_hsk | longp_hsk;

  assign alu_req   = '{idx: wb.alu_wbck_idx,
                       dat: wb.alu_wbck_dat};
  assign longp_req = '{idx: wb.longp_wbck_idx,
                       dat: wb.longp_wbck_dat};
  assign win_req   = alu_hsk ? alu_req : longp_req;

  // x0 writes still handshake but never reach the regfile
  assign wen_nxt = any_hsk & ~is_x0(win_req);

  sirv_gnrl_dfflr #(.DW(1)) u_wen (
    .lden  (1'b1),
    .dnxt  (wen_nxt),
    .qout  (wen_q),
    .clk   (clk),
    .rst_n (rst_n)
  );

  sirv_gnrl_dfflr #(.DW($bits(wbck_req_t))) u_req (
    .lden  (any_hsk),
    .dnxt  (win_req),
    .qout  (rf_q),
    .clk   (clk),
    .rst_n (rst_n)
  );

  assign wb.rf_wbck_wen = wen_q;
  assign wb.rf_wbck_idx = rf_q.idx;
  assign wb.rf_wbck_dat = rf_q.dat;

endmodule

// File: tb/tb_e203_exu_wbck_arb.sv
// Scoreboard bench for the writeback arbiter with a
// cycle-level grant model and a shadow regfile.
module tb_e203_exu_wbck_arb;
  import e203_exu_pkg::*;

  localparam int SM = 4;

  typedef struct {
    logic [RFIDX_W-1:0] idx;
    logic [XLEN-1:0]    dat;
    int                 stamp;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sf1, sf0;

  e203_exu_wbck_arb_if wb1();
  e203_exu_wbck_arb_if wb0();

  e203_exu_wbck_arb #(.STARVE_MAX(SM)) dut (
    .clk (clk), .rst_n (rst_n),
    .wb (wb1), .starve_force (sf1)
  );

  e203_exu_wbck_arb #(.STARVE_MAX(0)) dut0 (
    .clk (clk), .rst_n (rst_n),
    .wb (wb0), .starve_force (sf0)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;
  int streak = 0;
  bit mon_en = 1'b0;
  exp_t expq[$];
  logic [XLEN-1:0] rf_model [32];
  logic [XLEN-1:0] shadow   [32];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    n_tot++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cyc %0d)",
                  nm, act, req, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (wb1.rf_wbck_wen) shadow[wb1.rf_wbck_idx] <= wb1.rf_wbck_dat;

  // Monitor: retire expected writes when the DUT presents them
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (mon_en && rst_n) begin
      if (wb1.rf_wbck_wen) begin
        if (expq.size() == 0) chk("spurious_wen", wb1.rf_wbck_wen, 0);
        else begin
          e = expq.pop_front();
          chk("wb_idx", wb1.rf_wbck_idx, e.idx);
          chk("wb_dat", wb1.rf_wbck_dat, e.dat);
          chk("wb_lat", cyc - 1, e.stamp);
          rf_model[e.idx] = e.dat;
        end
      end else if (expq.size() != 0 && expq[0].stamp < cyc) begin
        e = expq.pop_front();
        chk("wb_missing", wb1.rf_wbck_wen, 1);
      end
    end
  end

  task automatic drive1(input logic av, input logic [4:0] ai,
                        input logic [31:0] ad, input logic lv,
                        input logic [4:0] li, input logic [31:0] ld);
    wb1.alu_wbck_valid   = av;
    wb1.alu_wbck_idx     = ai;
    wb1.alu_wbck_dat     = ad;
    wb1.longp_wbck_valid = lv;
    wb1.longp_wbck_idx   = li;
    wb1.longp_wbck_dat   = ld;
  endtask

  // One cycle: drive, check grants against the model, queue the write
  task automatic step(input logic av, input logic [4:0] ai,
                      input logic [31:0] ad, input logic lv,
                      input logic [4:0] li, input logic [31:0] ld,
                      output logic a_acc, output logic l_acc);
    bit f, ag, lg;
    exp_t e;
    @(negedge clk);
    drive1(av, ai, ad, lv, li, ld);
    #1;
    f  = (SM != 0) && (streak == SM) && av;
    ag = av && (!lv || f);
    lg = lv && !f;
    chk("starve_force", sf1, f);
    chk("alu_ready", wb1.alu_wbck_ready, !lv || f);
    chk("longp_ready", wb1.longp_wbck_ready, !f);
    a_acc = av & wb1.alu_wbck_ready;
    l_acc = lv & wb1.longp_wbck_ready;
    e.stamp = cyc;
    if (ag && ai != 0) begin
      e.idx = ai; e.dat = ad; expq.push_back(e);
    end
    if (lg && li != 0) begin
      e.idx = li; e.dat = ld; expq.push_back(e);
    end
    if (ag)            streak = 0;
    else if (av && lg) streak = (streak + 1 > SM) ? SM : streak + 1;
    else if (!av)      streak = 0;
  endtask

  task automatic idle(input int n);
    logic a, l;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, a, l);
  endtask

  initial begin
    logic a, l;
    logic av, lv;
    logic [4:0] ai, li;
    logic [31:0] ad, ld;
    int n;

    for (int i = 0; i < 32; i++) begin
      rf_model[i] = '0;
      shadow[i]   = '0;
    end
    wb0.alu_wbck_valid = 0; wb0.alu_wbck_idx = 0;
    wb0.alu_wbck_dat = 0; wb0.longp_wbck_valid = 0;
    wb0.longp_wbck_idx = 0; wb0.longp_wbck_dat = 0;

    // Reset held with both sources requesting
    drive1(1, 4, 32'hA, 1, 3, 32'hB);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_wen", wb1.rf_wbck_wen, 0);
    chk("rst_idx", wb1.rf_wbck_idx, 0);
    chk("rst_dat", wb1.rf_wbck_dat, 0);
    chk("rst_force", sf1, 0);
    chk("rst_longp_ready", wb1.longp_wbck_ready, 1);
    chk("rst_alu_ready", wb1.alu_wbck_ready, 0);
    drive1(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // ALU alone to x5
    step(1, 5, 32'hDEAD_BEEF, 0, 0, 0, a, l);
    idle(2);

    // Starvation: longp wins SM times then ALU is forced
    n = 0; a = 0;
    for (int i = 0; i < 10 && !a; i++) begin
      step(1, 4, 32'hA4A4_0004, 1, 3, 32'hC3C3_0003, a, l);
      if (l) n++;
    end
    chk("starve_grants", n, SM);
    chk("starve_alu_won", a, 1);
    step(1, 4, 32'hA4A4_1004, 1, 3, 32'hC3C3_1003, a, l);
    chk("starve_reset_longp", l, 1);
    idle(2);

    // x0 write handshakes without writing
    step(1, 0, 32'h1234, 0, 0, 0, a, l);
    chk("x0_accepted", a, 1);
    idle(2);

    // Randomized traffic with held requests
    av = 0; lv = 0; ai = 0; li = 0; ad = 0; ld = 0;
    for (int i = 0; i < 400; i++) begin
      if (!av && $urandom_range(2) == 0) begin
        av = 1; ai = 5'($urandom_range(7)); ad = $urandom;
      end
      if (!lv && $urandom_range(1) == 0) begin
        lv = 1; li = 5'($urandom_range(7)); ld = $urandom;
      end
      step(av, ai, ad, lv, li, ld, a, l);
      if (a) av = 0;
      if (l) lv = 0;
    end
    idle(3);

    // Reset right after a longp handshake discards the write
    step(0, 0, 0, 1, 5, 32'h5555_0000, a, l);
    mon_en = 1'b0;
    drive1(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_discard_wen", wb1.rf_wbck_wen, 0);
    expq.delete();
    streak = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // Forcing disabled: ALU never wins
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      wb0.alu_wbck_valid = 1; wb0.alu_wbck_idx = 4;
      wb0.alu_wbck_dat = 32'hAAAA;
      wb0.longp_wbck_valid = 1; wb0.longp_wbck_idx = 3;
      wb0.longp_wbck_dat = 32'hBBBB;
      #1;
      chk("nf_alu_ready", wb0.alu_wbck_ready, 0);
      chk("nf_longp_ready", wb0.longp_wbck_ready, 1);
      chk("nf_force", sf0, 0);
      if (i > 0) begin
        chk("nf_wen", wb0.rf_wbck_wen, 1);
        chk("nf_idx", wb0.rf_wbck_idx, 3);
      end
    end
    @(negedge clk);
    wb0.alu_wbck_valid = 0; wb0.longp_wbck_valid = 0;

    idle(3);
    chk("q_drain", expq.size(), 0);
    for (int r = 0; r < 32; r++)
      chk($sformatf("rf_x%0d", r), shadow[r], rf_model[r]);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
